// File: rtl/alu_share_arb.sv
// alu_share_arb: one integer ALU shared by two requesters. Round-robin grant,
// a single operation in flight, and a registered, tagged response channel
// with valid/ready backpressure.
module alu_share_arb #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OPW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [OPW-1:0]  req0_op_i,
    input  logic [XLEN-1:0] req0_rs1_i,
    input  logic [XLEN-1:0] req0_rs2_i,
    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [OPW-1:0]  req1_op_i,
    input  logic [XLEN-1:0] req1_rs1_i,
    input  logic [XLEN-1:0] req1_rs2_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic            rsp_id_o,
    output logic [XLEN-1:0] rsp_rd_o,
    output logic            rsp_err_o,
    output logic            busy_o
);

    localparam int unsigned ShW = $clog2(XLEN);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic [OPW-1:0] OpAdd  = OPW'(0);
    localparam logic [OPW-1:0] OpSub  = OPW'(1);
    localparam logic [OPW-1:0] OpSlt  = OPW'(2);
    localparam logic [OPW-1:0] OpSltu = OPW'(3);
    localparam logic [OPW-1:0] OpAnd  = OPW'(4);
    localparam logic [OPW-1:0] OpOr   = OPW'(5);
    localparam logic [OPW-1:0] OpXor  = OPW'(6);
    localparam logic [OPW-1:0] OpSll  = OPW'(7);
    localparam logic [OPW-1:0] OpSrl  = OPW'(8);
    localparam logic [OPW-1:0] OpSra  = OPW'(9);

    logic [1:0]      state_q, state_d;
    logic            rr_ptr_q;
    logic [OPW-1:0]  op_q;
    logic [XLEN-1:0] rs1_q, rs2_q;
    logic            id_q;
    logic            rsp_valid_q;
    logic            rsp_id_q;
    logic [XLEN-1:0] rsp_rd_q;
    logic            rsp_err_q;

    logic            idle;
    logic            any_valid;
    logic            grant;
    logic            hs;
    logic [ShW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            alu_err;

    // Grant selection: lone requester wins, contention resolved by rr_ptr.
    always_comb begin
        idle      = (state_q == StIdle);
        any_valid = req0_valid_i | req1_valid_i;
        grant     = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant = rr_ptr_q;
        end else if (req1_valid_i) begin
            grant = 1'b1;
        end
        hs           = idle & any_valid;
        req0_ready_o = hs & ~grant;
        req1_ready_o = hs & grant;
    end

    // FSM next state: IDLE -> EXEC -> RESP -> IDLE (held until consumer takes it).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (hs) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ALU datapath on the latched operands; codes 10-15 flag an error with zero result.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        shamt   = rs2_q[ShW-1:0];
        case (op_q)
            OpAdd:   alu_res = rs1_q + rs2_q;
            OpSub:   alu_res = rs1_q - rs2_q;
            OpSlt:   alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_q) < $signed(rs2_q))};
            OpSltu:  alu_res = {{(XLEN-1){1'b0}}, (rs1_q < rs2_q)};
            OpAnd:   alu_res = rs1_q & rs2_q;
            OpOr:    alu_res = rs1_q | rs2_q;
            OpXor:   alu_res = rs1_q ^ rs2_q;
            OpSll:   alu_res = rs1_q << shamt;
            OpSrl:   alu_res = rs1_q >> shamt;
            OpSra:   alu_res = XLEN'($signed(rs1_q) >>> shamt);
            default: alu_err = 1'b1;
        endcase
    end

    // State, operand capture on handshake, and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= 1'b0;
            op_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_rd_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                op_q     <= grant ? req1_op_i  : req0_op_i;
                rs1_q    <= grant ? req1_rs1_i : req0_rs1_i;
                rs2_q    <= grant ? req1_rs2_i : req0_rs2_i;
                id_q     <= grant;
                // Favour the other requester next time.
                rr_ptr_q <= ~grant;
            end
            if (state_q == StExec) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= id_q;
                rsp_rd_q    <= alu_res;
                rsp_err_q   <= alu_err;
            end else if (state_q == StResp && rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_rd_o    = rsp_rd_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a response scoreboard.
module tb_alu_share_arb;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_rs1, req0_rs2;
    logic        req1_valid, req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_rs1, req1_rs2;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [31:0] rsp_rd;

    typedef struct packed {
        logic        id;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    alu_share_arb #(.XLEN(32), .OPW(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_op_i    (req0_op),
        .req0_rs1_i   (req0_rs1),
        .req0_rs2_i   (req0_rs2),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_op_i    (req1_op),
        .req1_rs1_i   (req1_rs1),
        .req1_rs2_i   (req1_rs2),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_rd_o     (rsp_rd),
        .rsp_err_o    (rsp_err),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed=response expected=none_queued", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_id"},  32'(rsp_id),  32'(e.id));
            chk({tag, "_rd"},  rsp_rd,       e.rd);
            chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
        end
    endtask

    task automatic drive(input bit idx, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        if (idx == 1'b0) begin
            req0_valid = 1'b1; req0_op = op; req0_rs1 = a; req0_rs2 = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_rs1 = a; req1_rs2 = b;
        end
    endtask

    // Called just after a rising edge in IDLE with the other requester idle;
    // returns just after the rising edge that closes the RESP cycle.
    task automatic do_op(input bit idx, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_rd,
                         input bit exp_err, input string tag);
        drive(idx, op, a, b);
        @(negedge clk);
        chk({tag, "_rdy"},   32'(idx ? req1_ready : req0_ready), 32'd1);
        chk({tag, "_other"}, 32'(idx ? req0_ready : req1_ready), 32'd0);
        sb.push_back('{id: idx, rd: exp_rd, err: exp_err});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_exec_busy"},  32'(busy),      32'd1);
        chk({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        pop_chk(tag);
        @(posedge clk); #1;
    endtask

    initial begin
        int gcnt;
        rst_n      = 1'b0;
        rsp_ready  = 1'b1;
        req0_valid = 1'b0; req0_op = '0; req0_rs1 = '0; req0_rs2 = '0;
        req1_valid = 1'b0; req1_op = '0; req1_rs1 = '0; req1_rs2 = '0;

        // Reset state
        #2;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_rd",    rsp_rd,         32'd0);
        chk("rst_id",    32'(rsp_id),    32'd0);
        chk("rst_err",   32'(rsp_err),   32'd0);

        // Both requesters valid from reset: strict alternation starting at 0
        drive(0, 4'd0, 32'd5, 32'd6);
        drive(1, 4'd6, 32'd12, 32'd10);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        gcnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                chk("rr_onehot", 32'(req0_ready & req1_ready), 32'd0);
                chk("rr_grant",  32'(req1_ready), 32'(gcnt % 2));
                sb.push_back('{id: 1'(gcnt % 2), rd: (gcnt % 2 == 1) ? 32'd6 : 32'd11,
                               err: 1'b0});
                gcnt++;
            end
            if (rsp_valid) pop_chk("rr_rsp");
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rr_count", 32'(gcnt), 32'd4);
        chk("rr_drained", 32'(sb.size()), 32'd0);

        // Signed compare
        do_op(0, 4'd2, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, "slt_m1_1");
        do_op(0, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 1'b0, "slt_m1_m2");
        do_op(0, 4'd2, 32'd2, 32'd1, 32'd0, 1'b0, "slt_2_1");
        do_op(0, 4'd2, 32'd1, 32'd1, 32'd0, 1'b0, "slt_1_1");

        // Requester 1: unsigned compare, wrap, arithmetic shift
        do_op(1, 4'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, "sltu");
        do_op(1, 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, "sub_wrap");
        do_op(1, 4'd9, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, "sra31");

        // Remaining ops; shift amount uses only rs2[4:0]
        do_op(0, 4'd4, 32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 1'b0, "and");
        do_op(1, 4'd5, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, "or");
        do_op(0, 4'd7, 32'd1, 32'd33, 32'd2, 1'b0, "sll_mask");
        do_op(1, 4'd8, 32'h8000_0000, 32'd31, 32'd1, 1'b0, "srl31");

        // Illegal op then recovery
        do_op(0, 4'hC, 32'd7, 32'd3, 32'd0, 1'b1, "illegal");
        do_op(0, 4'd0, 32'd7, 32'd3, 32'd10, 1'b0, "add_after");

        // Backpressure: response held for 5 cycles, no grants meanwhile
        rsp_ready = 1'b0;
        drive(0, 4'd0, 32'd100, 32'd23);
        @(negedge clk);
        chk("bp_rdy0", 32'(req0_ready), 32'd1);
        sb.push_back('{id: 1'b0, rd: 32'd123, err: 1'b0});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drive(1, 4'd1, 32'd50, 32'd8);
        @(negedge clk);
        chk("bp_exec_rdy1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        chk("bp_valid", 32'(rsp_valid), 32'd1);
        pop_chk("bp_rsp");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(rsp_valid),  32'd1);
            chk("bp_hold_rd",    rsp_rd,          32'd123);
            chk("bp_hold_id",    32'(rsp_id),     32'd0);
            chk("bp_hold_err",   32'(rsp_err),    32'd0);
            chk("bp_hold_rdy",   32'(req0_ready | req1_ready), 32'd0);
            chk("bp_hold_busy",  32'(busy),       32'd1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_last_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_idle_valid", 32'(rsp_valid),  32'd0);
        chk("bp_idle_rdy1",  32'(req1_ready), 32'd1);
        sb.push_back('{id: 1'b1, rd: 32'd42, err: 1'b0});
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_valid", 32'(rsp_valid), 32'd1);
        pop_chk("bp_next");
        @(posedge clk); #1;

        // Reset during EXEC: rr_ptr set to 1 first, must return to 0
        do_op(0, 4'd0, 32'd2, 32'd3, 32'd5, 1'b0, "pre_rst");
        drive(0, 4'd0, 32'd1, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy",  32'(busy),      32'd0);
        chk("mid_rst_rd",    rsp_rd,         32'd0);
        chk("mid_rst_id",    32'(rsp_id),    32'd0);
        chk("mid_rst_err",   32'(rsp_err),   32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, 4'd1, 32'd9, 32'd4);
        drive(1, 4'd4, 32'hFF00_FF00, 32'h0FF0_0FF0);
        @(negedge clk);
        chk("post_rst_valid", 32'(rsp_valid),  32'd0);
        chk("post_rst_rdy0",  32'(req0_ready), 32'd1);
        chk("post_rst_rdy1",  32'(req1_ready), 32'd0);
        sb.push_back('{id: 1'b0, rd: 32'd5, err: 1'b0});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_exec_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        pop_chk("post_rst_r0");
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_rdy1b", 32'(req1_ready), 32'd1);
        sb.push_back('{id: 1'b1, rd: 32'h0F00_0F00, err: 1'b0});
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_valid_r1", 32'(rsp_valid), 32'd1);
        pop_chk("post_rst_r1");
        @(posedge clk); #1;

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
